alu_div_core: RTL

ALU_DIV_CORE -- requirements
Module: alu_div_core

---
 rtl/alu_div_core_pkg.sv | 38 +++
 rtl/alu_div_core_step.sv | 21 ++
 rtl/alu_div_core.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_div_core_pkg.sv
// Shared types, widths and the result-finishing helper for the iterative divider.
package alu_div_core_pkg;

  localparam int unsigned DIV_XLEN  = 64;
  localparam int unsigned DIV_WLEN  = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Pick quotient/remainder, apply sign correction, word sign-extension and divide-by-zero rules.
  function automatic logic [DIV_XLEN-1:0] div_finish(
    input logic [DIV_XLEN-1:0] q,
    input logic [DIV_XLEN-1:0] r,
    input logic                op_w,
    input logic                op_rem,
    input logic                is_signed,
    input logic                neg_q,
    input logic                neg_r,
    input logic                dz,
    input logic [DIV_XLEN-1:0] dz_rem
  );
    logic [DIV_XLEN-1:0] v;
    v = '0;
    if (dz) begin
      v = op_rem ? dz_rem : '1;
    end else begin
      v = op_rem ? r : q;
      if (is_signed && (op_rem ? neg_r : neg_q)) v = -v;
      if (op_w) v = {{(DIV_XLEN-DIV_WLEN){v[DIV_WLEN-1]}}, v[DIV_WLEN-1:0]};
    end
    return v;
  endfunction

endpackage

// File: rtl/alu_div_core_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial-subtract the divisor.
module alu_div_step
  import alu_div_core_pkg::*;
(
  input  logic [DIV_XLEN-1:0] rem,
  input  logic                dbit,
  input  logic [DIV_XLEN-1:0] divisor,
  output logic [DIV_XLEN-1:0] rem_next,
  output logic                q_bit
);

  logic [DIV_XLEN:0] shifted;
  logic [DIV_XLEN:0] diff;

  // The partial remainder is always below the divisor, so a 65-bit trial is enough.
  assign shifted  = {rem, dbit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[DIV_XLEN];
  assign rem_next = q_bit ? diff[DIV_XLEN-1:0] : shifted[DIV_XLEN-1:0];

endmodule

// File: rtl/alu_div_core.sv
// Iterative restoring divider for 64-bit and 32-bit word DIV/REM ops, signed and unsigned.
// Optional macro DIV_EARLY_OUT_EN finishes trivial cases (divide-by-zero, |a| < |b|) after one BUSY cycle.
module alu_div_core
  import alu_div_core_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_w,
  input  logic                op_rem,
  input  logic                op_unsigned,
  input  logic [DIV_XLEN-1:0] a_raw,
  input  logic [DIV_XLEN-1:0] b_raw,
  input  logic [DIV_XLEN-1:0] a_mag,
  input  logic [DIV_XLEN-1:0] b_mag,
  input  logic [DIV_WLEN-1:0] aw_mag,
  input  logic [DIV_WLEN-1:0] bw_mag,
  input  logic                sign_q,
  input  logic                sign_r,
  input  logic                sign_qw,
  input  logic                sign_rw,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIV_XLEN-1:0] result
);

  localparam int unsigned HIW = DIV_XLEN - DIV_WLEN;

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DIV_XLEN-1:0]  quo;
  logic [DIV_XLEN-1:0]  rem;
  logic [DIV_XLEN-1:0]  dvsr;
  logic [DIV_XLEN-1:0]  dz_rem;
  logic                 w_q;
  logic                 rem_q;
  logic                 signed_q;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz_q;

  logic [DIV_XLEN-1:0]  a_sel;
  logic [DIV_XLEN-1:0]  b_sel;
  logic [DIV_XLEN-1:0]  a_align;
  logic [DIV_XLEN-1:0]  in_dz_rem;
  logic                 in_dz;
  logic [DIV_XLEN-1:0]  step_rem;
  logic                 step_q;
  logic [DIV_XLEN-1:0]  quo_next;
  logic                 last;
  logic [DIV_XLEN-1:0]  fin_result;

  // Operand selection; word dividends are left-aligned so the next bit is always quo's MSB.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    if (op_unsigned) begin
      a_sel = op_w ? {{HIW{1'b0}}, a_raw[DIV_WLEN-1:0]} : a_raw;
      b_sel = op_w ? {{HIW{1'b0}}, b_raw[DIV_WLEN-1:0]} : b_raw;
    end else begin
      a_sel = op_w ? {{HIW{1'b0}}, aw_mag} : a_mag;
      b_sel = op_w ? {{HIW{1'b0}}, bw_mag} : b_mag;
    end
  end

  assign a_align   = op_w ? {a_sel[DIV_WLEN-1:0], {HIW{1'b0}}} : a_sel;
  assign in_dz     = (b_sel == '0);
  assign in_dz_rem = op_w ? {{HIW{a_raw[DIV_WLEN-1]}}, a_raw[DIV_WLEN-1:0]} : a_raw;

  alu_div_step u_step (
    .rem      (rem),
    .dbit     (quo[DIV_XLEN-1]),
    .divisor  (dvsr),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign quo_next   = {quo[DIV_XLEN-2:0], step_q};
  assign last       = w_q ? (cnt == DIV_CNT_W'(DIV_WLEN - 1)) : (cnt == DIV_CNT_W'(DIV_XLEN - 1));
  assign fin_result = div_finish(quo_next, step_rem, w_q, rem_q, signed_q, neg_q, neg_r, dz_q, dz_rem);

`ifdef DIV_EARLY_OUT_EN
  logic                early_q;
  logic [DIV_XLEN-1:0] early_result;
  // Trivial case: quotient 0, remainder is the unshifted dividend held in quo.
  assign early_result = div_finish('0, w_q ? {{HIW{1'b0}}, quo[DIV_XLEN-1:HIW]} : quo,
                                   w_q, rem_q, signed_q, neg_q, neg_r, dz_q, dz_rem);
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      dz_rem   <= '0;
      w_q      <= 1'b0;
      rem_q    <= 1'b0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      result   <= '0;
`ifdef DIV_EARLY_OUT_EN
      early_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            cnt      <= '0;
            quo      <= a_align;
            rem      <= '0;
            dvsr     <= b_sel;
            dz_rem   <= in_dz_rem;
            w_q      <= op_w;
            rem_q    <= op_rem;
            signed_q <= ~op_unsigned;
            neg_q    <= op_w ? sign_qw : sign_q;
            neg_r    <= op_w ? sign_rw : sign_r;
            dz_q     <= in_dz;
`ifdef DIV_EARLY_OUT_EN
            early_q  <= in_dz || (a_sel < b_sel);
`endif
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (early_q) begin
            state  <= DONE;
            result <= early_result;
          end
`endif
          else begin
            quo <= quo_next;
            rem <= step_rem;
            cnt <= cnt + DIV_CNT_W'(1);
            if (last) begin
              state  <= DONE;
              result <= fin_result;
            end
          end
        end
        DONE: begin
          if (flush || out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
